multicycle_sum_tree: RTL
========================

# multicycle_sum_tree

Parametrised, time-multiplexed reduction adder. It sums `N_INPUTS` operands of `IN_W` bits using a pool of `N_ADDERS` shared pipelined adders, each with `ADD_LAT` cycles of latency, and schedules the work level by level under an FSM. It sits in the datapath wherever a wide vector sum is needed without a full-width combinational tree. A valid/ready handshake on both sides and a per-transaction signed/unsigned mode replace the fixed 30-input, 5-state schedule of the previous generation.

## Interface
- `N_INPUTS`, 30: number of operands, ≥1.
- `IN_W`, 8: operand width.
- `N_ADDERS`, 6: shared adder instances, ≥1.
- `ADD_LAT`, 2: pipeline depth of each shared adder, ≥1.
- `OUT_W`, derived, `IN_W + $clog2(N_INPUTS)` (minimum `IN_W`): result width. Not overridable.
- `clk` input 1: single clock, rising edge.
- `rst` input 1: reset, asynchronous, active-high.
- `in_valid` input 1: operand vector valid.
- `in_ready` output 1: block can accept a vector.
- `in_data` input `N_INPUTS*IN_W`: operand i at bits `[i*IN_W +: IN_W]`.
- `in_signed` input 1: 1 = operands are two's complement; sampled with `in_data`.
- `out_valid` output 1: `out_sum` holds a result.
- `out_ready` input 1: consumer accepts the result.
- `out_sum` output `OUT_W`: sum. Sign-extended if signed, zero-extended otherwise.
- `busy` output 1: high from accept until the result handshake completes.

## Operation
- FSM states are IDLE, ISSUE, DRAIN and DONE.
- IDLE:
  - `in_ready` = 1.
  - On `in_valid && in_ready`, all operands are captured into the operand buffer, extended to `OUT_W` according to `in_signed`.
  - The level count is set to n = `N_INPUTS`.
  - Next state is ISSUE, or DONE when n = 1.
- ISSUE handles level k with n_k operands:
  - There are pairs_k = floor(n_k/2) additions.
  - Up to `N_ADDERS` pairs are issued per cycle, in ascending operand order.
  - The level therefore takes I_k = ceil(pairs_k/`N_ADDERS`) issue cycles.
  - When n_k is odd, the last operand passes unchanged to the next level.
  - After the last issue cycle the FSM goes to DRAIN.
- DRAIN:
  - Waits exactly `ADD_LAT` cycles.
  - Results are written back as the next level's operands, with n_{k+1} = ceil(n_k/2).
  - Next state is ISSUE if n_{k+1} > 1, else DONE.
- DONE:
  - `out_valid` = 1 and `out_sum` holds the buffer entry 0.
  - Both are held stable until `out_ready`.
  - On the handshake the FSM returns to IDLE and `in_ready` rises the next cycle.
- There is no overlap: `in_ready` = 0 in ISSUE, DRAIN and DONE.
- Arithmetic:
  - All internal adds are `OUT_W` wide, with no overflow possible by construction.
  - The signed/unsigned choice only affects operand extension.
- Shared adder:
  - An unconditioned `ADD_LAT`-stage register pipeline.
  - Issue-cycle operand muxes feed it; idle slots are fed zero.

## Timing
- Cycle 0 is the rising edge where the input handshake occurs.
- `out_valid` rises at edge L = 1 + Σ_k (I_k + `ADD_LAT`).
  - Defaults (30, 6, 2): levels 30→15→8→4→2→1, with I = 3, 2, 1, 1, 1, giving L = 19.
  - `N_INPUTS` = 1: L = 1 and the input is passed straight through.
- `out_ready` held high when `out_valid` rises: the handshake happens in that cycle, and `in_ready` = 1 on the following cycle.
- `out_ready` low: the result is held indefinitely and `busy` stays high.
- `in_valid` while `in_ready` = 0 is ignored, and `in_data` is not sampled.
- Reset values (asynchronous, immediate): state IDLE, `in_ready` 1, `out_valid` 0, `out_sum` 0, `busy` 0, all pipelines cleared.
- Reset asserted mid-operation aborts the transaction. No partial result ever appears, and the first cycle after deassertion accepts new input.

## Test plan
- Defaults, unsigned, all operands 255 → `out_sum` = 7650 with `out_valid` at edge 19 and `busy` high for cycles 1–19.
- Defaults, signed, all operands 0x80 → `out_sum` = 13'h1100 (−3840). Same vector with `in_signed` = 0 → 3840.
- Defaults, operand i = i → 435. A second back-to-back vector of operand i = 29−i is accepted only after the first result handshake, and also gives 435.
- Backpressure: `out_ready` = 0 for 10 cycles after `out_valid` → `out_sum` stays stable, and `in_valid` pulses in that window are ignored.
- Reset asserted at cycle 7 of a transaction → `out_valid` never rises for it, `in_ready` = 1 immediately, and the next vector of all 1s → 30.
- `N_INPUTS`=5, `N_ADDERS`=1, `ADD_LAT`=1, operands 1..5 → 15 at L = 8. `N_INPUTS`=1, operand 200 → 200 at L = 1.

Source files
------------

// File: rtl/multicycle_sum_tree_if.sv
// Handshake bundle for multicycle_sum_tree: operand vector in, reduced sum out.
interface multicycle_sum_tree_if #(
    parameter int N_INPUTS = 30,
    parameter int IN_W     = 8
);
    localparam int OUT_W = IN_W + $clog2(N_INPUTS);

    logic                     in_valid;
    logic                     in_ready;
    logic [N_INPUTS*IN_W-1:0] in_data;
    logic                     in_signed;
    logic                     out_valid;
    logic                     out_ready;
    logic [OUT_W-1:0]         out_sum;
    logic                     busy;

    modport slave (
        input  in_valid, in_data, in_signed, out_ready,
        output in_ready, out_valid, out_sum, busy
    );

    modport master (
        output in_valid, in_data, in_signed, out_ready,
        input  in_ready, out_valid, out_sum, busy
    );
endinterface

// File: rtl/multicycle_sum_tree.sv
// Time-multiplexed reduction adder: sums N_INPUTS operands level by level
// through a pool of N_ADDERS shared ADD_LAT-deep pipelined adders.
//
// state   | meaning
// IDLE    | ready for a vector; capture and extend operands on handshake
// ISSUE   | feed up to N_ADDERS pairs of the current level per cycle
// DRAIN   | wait ADD_LAT cycles for the level's last results to land
// DONE    | present buffer entry 0 until the consumer takes it
module multicycle_sum_tree #(
    parameter int N_INPUTS = 30,
    parameter int IN_W     = 8,
    parameter int N_ADDERS = 6,
    parameter int ADD_LAT  = 2
) (
    input  logic                  clk,
    input  logic                  rst,
    multicycle_sum_tree_if.slave  bus
);
    localparam int OUT_W = IN_W + $clog2(N_INPUTS);
    localparam int CNT_W = $clog2(N_INPUTS + 1);
    localparam int IDX_W = (N_INPUTS > 1) ? $clog2(N_INPUTS) : 1;
    localparam int DRN_W = (ADD_LAT > 1) ? $clog2(ADD_LAT) : 1;

    typedef enum logic [1:0] {S_IDLE, S_ISSUE, S_DRAIN, S_DONE} state_t;

    state_t           r_state;
    state_t           w_state_nxt;

    logic [OUT_W-1:0] r_buf [N_INPUTS];
    logic [CNT_W-1:0] r_n;
    logic [CNT_W-1:0] r_pair_base;
    logic [DRN_W-1:0] r_drain_cnt;
    logic             r_out_valid;
    logic [OUT_W-1:0] r_out_sum;

    logic [OUT_W-1:0] r_pipe_sum [N_ADDERS][ADD_LAT];
    logic             r_pipe_vld [N_ADDERS][ADD_LAT];
    logic [IDX_W-1:0] r_pipe_dst [N_ADDERS][ADD_LAT];

    logic [OUT_W-1:0] w_op_a     [N_ADDERS];
    logic [OUT_W-1:0] w_op_b     [N_ADDERS];
    logic             w_slot_vld [N_ADDERS];
    logic [IDX_W-1:0] w_slot_dst [N_ADDERS];

    logic [CNT_W-1:0] w_pairs;
    logic [CNT_W-1:0] w_n_next;
    logic [IDX_W-1:0] w_mid_idx;
    logic [IDX_W-1:0] w_last_idx;
    logic             w_last_issue;
    logic             w_accept;
    logic             w_issue_en;
    logic             w_level_end;
    logic             w_in_ready;
    logic             w_busy;

    assign w_pairs      = r_n >> 1;
    assign w_n_next     = (r_n >> 1) + CNT_W'(r_n[0]);
    assign w_mid_idx    = IDX_W'(w_pairs);
    assign w_last_idx   = IDX_W'(r_n - 1'b1);
    assign w_last_issue = (int'(r_pair_base) + N_ADDERS) >= int'(w_pairs);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            S_IDLE: begin
                if (bus.in_valid) begin
                    w_state_nxt = (N_INPUTS == 1) ? S_DONE : S_ISSUE;
                end
            end
            S_ISSUE: begin
                if (w_last_issue) begin
                    w_state_nxt = S_DRAIN;
                end
            end
            S_DRAIN: begin
                if (r_drain_cnt == '0) begin
                    w_state_nxt = (w_n_next > CNT_W'(1)) ? S_ISSUE : S_DONE;
                end
            end
            S_DONE: begin
                if (r_out_valid && bus.out_ready) begin
                    w_state_nxt = S_IDLE;
                end
            end
            default: w_state_nxt = S_IDLE;
        endcase
    end

    always_comb begin
        w_accept    = 1'b0;
        w_issue_en  = 1'b0;
        w_level_end = 1'b0;
        w_in_ready  = 1'b0;
        w_busy      = 1'b1;
        case (r_state)
            S_IDLE: begin
                w_in_ready = 1'b1;
                w_busy     = 1'b0;
                w_accept   = bus.in_valid;
            end
            S_ISSUE: w_issue_en  = 1'b1;
            S_DRAIN: w_level_end = (r_drain_cnt == '0);
            default: ;
        endcase
    end

    assign bus.in_ready  = w_in_ready;
    assign bus.busy      = w_busy;
    assign bus.out_valid = r_out_valid;
    assign bus.out_sum   = r_out_sum;

    // Slot j takes pair (base + j); pair p reads operands 2p, 2p+1 and lands at p.
    always_comb begin
        for (int j = 0; j < N_ADDERS; j++) begin
            w_op_a[j]     = '0;
            w_op_b[j]     = '0;
            w_slot_vld[j] = 1'b0;
            w_slot_dst[j] = '0;
            if (w_issue_en && ((int'(r_pair_base) + j) < int'(w_pairs))) begin
                w_slot_vld[j] = 1'b1;
                w_slot_dst[j] = IDX_W'(int'(r_pair_base) + j);
                w_op_a[j]     = r_buf[IDX_W'(2 * (int'(r_pair_base) + j))];
                w_op_b[j]     = r_buf[IDX_W'(2 * (int'(r_pair_base) + j) + 1)];
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int j = 0; j < N_ADDERS; j++) begin
                for (int s = 0; s < ADD_LAT; s++) begin
                    r_pipe_sum[j][s] <= '0;
                    r_pipe_vld[j][s] <= 1'b0;
                    r_pipe_dst[j][s] <= '0;
                end
            end
        end else begin
            for (int j = 0; j < N_ADDERS; j++) begin
                r_pipe_sum[j][0] <= w_op_a[j] + w_op_b[j];
                r_pipe_vld[j][0] <= w_slot_vld[j];
                r_pipe_dst[j][0] <= w_slot_dst[j];
                for (int s = 1; s < ADD_LAT; s++) begin
                    r_pipe_sum[j][s] <= r_pipe_sum[j][s-1];
                    r_pipe_vld[j][s] <= r_pipe_vld[j][s-1];
                    r_pipe_dst[j][s] <= r_pipe_dst[j][s-1];
                end
            end
        end
    end

    // Write-back targets always sit below the indices still being read, so
    // results can land while the same level is still issuing.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < N_INPUTS; i++) begin
                r_buf[i] <= '0;
            end
        end else if (w_accept) begin
            for (int i = 0; i < N_INPUTS; i++) begin
                r_buf[i] <= bus.in_signed ? OUT_W'($signed(bus.in_data[i*IN_W +: IN_W]))
                                          : OUT_W'(bus.in_data[i*IN_W +: IN_W]);
            end
        end else begin
            for (int j = 0; j < N_ADDERS; j++) begin
                if (r_pipe_vld[j][ADD_LAT-1]) begin
                    r_buf[r_pipe_dst[j][ADD_LAT-1]] <= r_pipe_sum[j][ADD_LAT-1];
                end
            end
            if (w_level_end && r_n[0]) begin
                r_buf[w_mid_idx] <= r_buf[w_last_idx];
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_n         <= '0;
            r_pair_base <= '0;
            r_drain_cnt <= '0;
            r_out_valid <= 1'b0;
            r_out_sum   <= '0;
        end else begin
            if (w_accept) begin
                r_n         <= CNT_W'(N_INPUTS);
                r_pair_base <= '0;
            end
            if (w_issue_en) begin
                if (w_last_issue) begin
                    r_pair_base <= '0;
                    r_drain_cnt <= DRN_W'(ADD_LAT - 1);
                end else begin
                    r_pair_base <= r_pair_base + CNT_W'(N_ADDERS);
                end
            end
            if (r_state == S_DRAIN) begin
                if (r_drain_cnt == '0) begin
                    r_n <= w_n_next;
                end else begin
                    r_drain_cnt <= r_drain_cnt - 1'b1;
                end
            end
            // Result is registered on the first DONE cycle and frozen until taken.
            if (r_state == S_DONE) begin
                if (!r_out_valid) begin
                    r_out_valid <= 1'b1;
                    r_out_sum   <= r_buf[0];
                end else if (bus.out_ready) begin
                    r_out_valid <= 1'b0;
                end
            end
        end
    end
endmodule
